// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX serializer: FSM state encoding,
// parity mode encodings, data-length base and the frame-start helper functions.
package uart_pkg;

    // Data length is encoded as an offset from five bits.
    localparam int DATA_LEN_BASE = 5;
    // Widest data field any build can carry; helpers work on this width.
    localparam int DATA_W_ABS    = 9;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

    // Active data length in bits, clamped to the widest field this build supports.
    function automatic logic [3:0] active_len(input logic [2:0] code, input logic [3:0] max_len);
        logic [3:0] len;
        len = 4'(DATA_LEN_BASE) + {1'b0, code};
        return (len > max_len) ? max_len : len;
    endfunction

    // Parity bit over the active data bits only; bits above len do not contribute.
    function automatic logic parity_bit(input logic [DATA_W_ABS-1:0] word,
                                        input logic [3:0]            len,
                                        input logic [1:0]            par);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < DATA_W_ABS; i++) begin
            if (4'(i) < len) acc = acc ^ word[i];
        end
        case (par)
            PAR_ODD:  return ~acc;
            PAR_EVEN: return acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// TX holding FIFO: first-word fall-through read port, registered full/empty/level.
// Writes are gated by the registered full flag, so a write while full is dropped
// even when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push, pop;

    assign push = wr_en & ~full_q;
    assign pop  = rd_en & ~empty_q;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        full_d   = (level_d == LVL_W'(DEPTH));
        empty_d  = (level_d == '0);
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: FIFO-fed frame builder shifting one bit per baud_tick.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
//
// state  | meaning
// IDLE   | line high, waiting for a word and a baud tick
// START  | start bit (low)
// DATA   | data bits, LSB first, bit_cnt counts remaining bits
// PARITY | parity bit
// STOP   | stop bit(s), bit_cnt counts extra stop bits left
// BREAK  | line held low while break_req (break builds only)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W_MAX = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            baud_tick,
    input  logic                            wr_en,
    input  logic [DATA_W_MAX-1:0]           wr_data,
    input  logic [2:0]                      cfg_data_len,
    input  logic [1:0]                      cfg_parity,
    input  logic                            cfg_stop2,
    input  logic                            break_req,
    output logic                            tx,
    output logic                            tx_active,
    output logic                            tx_done,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam logic [3:0] LEN_MAX = 4'(DATA_W_MAX);

    tx_state_e               state_q, state_d;
    logic [DATA_W_MAX-1:0]   data_q, data_d;
    logic [3:0]              len_q, len_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    stop2_q, stop2_d;
    logic                    tx_q, tx_d;
    logic                    tx_active_q, tx_active_d;
    logic                    tx_done_q, tx_done_d;

    logic                    pop;
    logic                    start_frame;
    logic [DATA_W_MAX-1:0]   fifo_rd_data;
    logic [DATA_W_ABS-1:0]   word_ext;
    logic [3:0]              new_len;
    logic                    new_par;

`ifdef UART_TX_BREAK_EN
    logic brk;
    assign brk = break_req;
`else
    logic unused_break_req;
    assign unused_break_req = break_req;
`endif

    uart_tx_fifo #(
        .W     (DATA_W_MAX),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Frame parameters are taken from the live config only at frame start.
    assign word_ext = DATA_W_ABS'(fifo_rd_data);
    assign new_len  = active_len(cfg_data_len, LEN_MAX);
    assign new_par  = parity_bit(word_ext, new_len, cfg_parity);

    // Next-state and next-output logic; nothing moves except on baud_tick.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        tx_d        = tx_q;
        tx_done_d   = 1'b0;
        start_frame = 1'b0;
        pop         = 1'b0;

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (brk) begin
                        state_d = BREAK;
                        tx_d    = 1'b0;
                    end else
`endif
                    if (!empty) start_frame = 1'b1;
                end
                START: begin
                    state_d   = DATA;
                    tx_d      = data_q[0];
                    data_d    = data_q >> 1;
                    bit_cnt_d = len_q - 4'd1;
                end
                DATA: begin
                    if (bit_cnt_q != 4'd0) begin
                        tx_d      = data_q[0];
                        data_d    = data_q >> 1;
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d   = STOP;
                        tx_d      = 1'b1;
                        bit_cnt_d = {3'b000, stop2_q};
                    end
                end
                PARITY: begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = {3'b000, stop2_q};
                end
                STOP: begin
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else begin
                        tx_done_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                        if (brk) begin
                            state_d = BREAK;
                            tx_d    = 1'b0;
                        end else
`endif
                        if (!empty) start_frame = 1'b1;
                        else        state_d     = IDLE;
                    end
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (!brk) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Shared by IDLE and the final stop bit so back-to-back frames need no idle tick.
        if (start_frame) begin
            pop       = 1'b1;
            state_d   = START;
            tx_d      = 1'b0;
            data_d    = fifo_rd_data;
            len_d     = new_len;
            par_en_d  = (cfg_parity != PAR_NONE);
            par_bit_d = new_par;
            stop2_d   = cfg_stop2;
        end

        tx_active_d = (state_d != IDLE);
    end

    // Frame registers and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            len_q       <= '0;
            bit_cnt_q   <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            stop2_q     <= stop2_d;
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx        = tx_q;
    assign tx_active = tx_active_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: table of hand-derived frames fed through a
// scoreboard queue of expected bit strings, plus sequences for FIFO overflow,
// back-to-back frames, reset mid-frame and (break builds) line break.
module tb_uart_tx_serializer;

    localparam int DW    = 9;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          baud_tick;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [2:0]    cfg_data_len;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          break_req;
    logic          tx, tx_active, tx_done, full, empty;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_W_MAX(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .cfg_data_len (cfg_data_len),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .break_req    (break_req),
        .tx           (tx),
        .tx_active    (tx_active),
        .tx_done      (tx_done),
        .full         (full),
        .empty        (empty),
        .level        (level)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus table: config, word, and the expected line sequence (start..stops, in send order).
    typedef struct {
        logic [2:0] dlen;
        logic [1:0] par;
        logic       stop2;
        logic [8:0] word;
        string      seq;
    } vec_t;
    vec_t vecs[7];

    // Scoreboard and line monitor state.
    string exp_q[$];
    bit    in_frame  = 0;
    string cur;
    int    pos       = 0;
    bit    done_due  = 0;
    int    frames_done = 0;
    int    done_cnt  = 0;
    int    pend_idle = 0;
    int    brk_ticks = 0;
    bit    brk_mode  = 0;
    logic  last_tx   = 1'b1;
    bit    acc_tick  = 0;

    // Baud tick generator.
    int tick_div = 4;
    bit tick_en  = 0;
    int tick_cnt = 0;
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                tick_cnt  = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
                baud_tick = (tick_cnt == 0);
            end else begin
                tick_cnt  = 0;
                baud_tick = 1'b0;
            end
        end
    end

    // Line monitor: samples 1 time unit after every rising edge.
    initial begin
        bit t;
        bit act_exp;
        forever begin
            @(posedge clk);
            t = baud_tick;
            #1;
            if (!rst) begin
                in_frame = 0;
                done_due = 0;
                pos      = 0;
                exp_q.delete();
                last_tx  = tx;
                continue;
            end
            if (tx_done) done_cnt++;
            if (!t) begin
                check("tx_stable", tx, last_tx);
                check("tx_done_nontick", tx_done, 1'b0);
            end else begin
                if (done_due) begin
                    check("tx_done_align", tx_done, 1'b1);
                    done_due = 0;
                end else begin
                    check("tx_done_spurious", tx_done, 1'b0);
                end
                act_exp = 1'b0;
                if (in_frame) begin
                    check("tx_bit", tx, (cur[pos] == "1"));
                    act_exp = 1'b1;
                    pos++;
                    if (pos == cur.len()) begin
                        in_frame = 0;
                        frames_done++;
                        done_due = 1;
                    end
                end else if (brk_mode && tx == 1'b0) begin
                    brk_ticks++;
                    act_exp = 1'b1;
                end else if (tx == 1'b0) begin
                    check("frame_expected", (exp_q.size() != 0), 1'b1);
                    act_exp = 1'b1;
                    if (exp_q.size() != 0) begin
                        cur      = exp_q.pop_front();
                        pos      = 1;
                        in_frame = 1;
                    end
                end else begin
                    brk_mode = 0;
                    if (exp_q.size() != 0) pend_idle++;
                end
                check("tx_active", tx_active, act_exp);
            end
            last_tx = tx;
        end
    end

    function automatic string frame_8n1(input logic [7:0] b);
        string s;
        s = "0";
        for (int i = 0; i < 8; i++) s = {s, (b[i] ? "1" : "0")};
        s = {s, "1"};
        return s;
    endfunction

    task automatic write_word(input logic [8:0] w, input bit accept, input string seq);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = w;
        if (accept) exp_q.push_back(seq);
        @(posedge clk);
        acc_tick = baud_tick;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_active(input int budget);
        int n = 0;
        while (!tx_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_active", tx_active, 1'b1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while ((frames_done < target || done_due) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_frames", (frames_done >= target && !done_due), 1'b1);
    endtask

    initial begin
        int base_done;
        int base_fr;
        int n;

        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done;
        int base_fr;
        int n;

        vecs[0] = '{3'd3, 2'b00, 1'b0, 9'h0A5, "0101001011"};
        vecs[1] = '{3'd2, 2'b10, 1'b1, 9'h041, "01000001011"};
        vecs[2] = '{3'd4, 2'b01, 1'b0, 9'h1FF, "011111111101"};
        vecs[3] = '{3'd0, 2'b11, 1'b0, 9'h01F, "01111111"};
        vecs[4] = '{3'd7, 2'b00, 1'b1, 9'h155, "010101010111"};
        vecs[5] = '{3'd1, 2'b10, 1'b0, 9'h1C3, "011000001"};
        vecs[6] = '{3'd0, 2'b01, 1'b1, 9'h00A, "001010111"};

        rst          = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        cfg_data_len = 3'd3;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        break_req    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx",        tx,        1'b1);
        check("rst_tx_active", tx_active, 1'b0);
        check("rst_tx_done",   tx_done,   1'b0);
        check("rst_full",      full,      1'b0);
        check("rst_empty",     empty,     1'b1);
        check("rst_level",     level,     '0);
        rst      = 1'b1;
        tick_div = 4;
        tick_en  = 1;

        // Table: one frame per vector, config scrambled once the frame has started.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cfg_data_len = vecs[i].dlen;
            cfg_parity   = vecs[i].par;
            cfg_stop2    = vecs[i].stop2;
            pend_idle    = 0;
            base_done    = done_cnt;
            base_fr      = frames_done;
            write_word(vecs[i].word, 1'b1, vecs[i].seq);
            wait_active(100);
            cfg_data_len = ~vecs[i].dlen;
            cfg_parity   = ~vecs[i].par;
            cfg_stop2    = ~vecs[i].stop2;
            wait_frames(base_fr + 1, 400);
            check("vec_done_count", done_cnt - base_done, 1);
            check("vec_start_latency", pend_idle, {31'd0, acc_tick});
            check("vec_empty", empty, 1'b1);
            check("vec_level", level, '0);
        end

        // Reset while in the data bits with a second word still queued.
        @(negedge clk);
        cfg_data_len = 3'd3;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        write_word(9'h0A5, 1'b1, frame_8n1(8'hA5));
        write_word(9'h03C, 1'b1, frame_8n1(8'h3C));
        n = 0;
        while (!(in_frame && pos >= 4) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reach_data", (in_frame && pos >= 4), 1'b1);
        check("level_before_rst", level, 1);
        @(negedge clk);
        base_done = done_cnt;
        rst = 1'b0;
        #1;
        check("mid_rst_tx",        tx,        1'b1);
        check("mid_rst_tx_active", tx_active, 1'b0);
        check("mid_rst_level",     level,     '0);
        check("mid_rst_empty",     empty,     1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        base_fr = frames_done;
        write_word(9'h05A, 1'b1, frame_8n1(8'h5A));
        wait_frames(base_fr + 1, 400);
        check("post_rst_done_count", done_cnt - base_done, 1);

        // Overflow and back-to-back frames with a tick every clock.
`ifndef UART_TX_BREAK_EN
        break_req = 1'b1;
`endif
        tick_en = 0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = 8'(k * 37 + 3);
            write_word({1'b0, b}, 1'b1, frame_8n1(b));
        end
        check("ovf_full",  full,  1'b1);
        check("ovf_level", level, 8);
        check("ovf_empty", empty, 1'b0);
        write_word(9'h0EE, 1'b0, "");
        check("ovf_level_after_drop", level, 8);
        check("ovf_full_after_drop",  full,  1'b1);
        base_done = done_cnt;
        base_fr   = frames_done;
        tick_div  = 1;
        tick_en   = 1;
        wait_active(50);
        pend_idle = 0;
        wait_frames(base_fr + 8, 2000);
        check("b2b_done_count", done_cnt - base_done, 8);
        check("b2b_idle_gaps",  pend_idle, 0);
        check("b2b_empty",      empty, 1'b1);
        check("b2b_level",      level, '0);
        check("b2b_queue_left", exp_q.size(), 0);
        break_req = 1'b0;

`ifdef UART_TX_BREAK_EN
        // Break for five ticks with a word waiting, then one idle tick before the frame.
        tick_en  = 0;
        tick_div = 4;
        @(negedge clk);
        cfg_data_len = 3'd3;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        write_word(9'h096, 1'b1, frame_8n1(8'h96));
        @(negedge clk);
        break_req = 1'b1;
        brk_mode  = 1;
        brk_ticks = 0;
        pend_idle = 0;
        base_fr   = frames_done;
        tick_en   = 1;
        n = 0;
        while (n < 5) begin
            @(posedge clk);
            if (baud_tick) n++;
        end
        @(negedge clk);
        break_req = 1'b0;
        wait_frames(base_fr + 1, 400);
        check("brk_low_ticks",  brk_ticks, 5);
        check("brk_idle_ticks", pend_idle, 1);
`endif

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
